// File: rtl/transpose_pp.sv
// transpose_pp: ping-pong matrix transposer.
// Columns fill one bank while the other drains rows.
module transpose_pp #(
  parameter int ROW_DIM    = 16,
  parameter int COL_DIM    = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(COL_DIM):0]      cfg_cols,
  input  logic [$clog2(ROW_DIM):0]      cfg_rows,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROW_DIM*DATA_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COL_DIM*DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int CW  = $clog2(COL_DIM) + 1;
  localparam int RW  = $clog2(ROW_DIM) + 1;
  localparam int CIW = (COL_DIM > 1) ? $clog2(COL_DIM) : 1;
  localparam int RIW = (ROW_DIM > 1) ? $clog2(ROW_DIM) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_e;

  logic [1:0]     bank_full;
  logic           wr_bank;
  logic           rd_bank;
  logic [CIW-1:0] wr_cnt;
  logic [RIW-1:0] rd_cnt;
  logic [CW-1:0]  c_q [2];
  logic [RW-1:0]  r_q [2];

  logic           wr_first;
  logic [CW-1:0]  wr_c;
  logic           wr_fire;
  logic           wr_done;
  logic [CW-1:0]  rd_c;
  logic [RW-1:0]  rd_r;
  logic           rd_fire;
  logic           rd_done;

  function automatic logic [CW-1:0] clamp_c(
    input logic [CW-1:0] v
  );
    if (v == '0)
      return CW'(1);
    if (v > CW'(COL_DIM))
      return CW'(COL_DIM);
    return v;
  endfunction

  function automatic logic [RW-1:0] clamp_r(
    input logic [RW-1:0] v
  );
    if (v == '0)
      return RW'(1);
    if (v > RW'(ROW_DIM))
      return RW'(ROW_DIM);
    return v;
  endfunction

  // Write side: the tile size is live on the
  // first beat so a one-column tile completes at once.
  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_first = (wr_cnt == '0);
  assign wr_c     = wr_first ? clamp_c(cfg_cols)
                             : c_q[wr_bank];
  assign wr_done  = wr_fire &&
                    (CW'(wr_cnt) == wr_c - CW'(1));

  // Read side status from registered state only.
  assign rd_c      = c_q[rd_bank];
  assign rd_r      = r_q[rd_bank];
  assign out_valid = bank_full[rd_bank];
  assign out_last  = out_valid &&
                     (RW'(rd_cnt) == rd_r - RW'(1));
  assign rd_fire   = out_valid && out_ready;
  assign rd_done   = rd_fire && out_last;

  assign busy = (|bank_full) || (wr_cnt != '0);

  // Per-bank lifecycle; full covers FULL and DRAINING.
  for (genvar b = 0; b < 2; b++) begin : gen_bank
    bank_st_e st_q;
    bank_st_e st_d;
    logic     wr_hit;
    logic     rd_hit;

    assign wr_hit = wr_fire && (wr_bank == 1'(b));
    assign rd_hit = rd_fire && (rd_bank == 1'(b));
    assign bank_full[b] = (st_q == FULL) ||
                          (st_q == DRAINING);

    // Bank state register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        st_q <= EMPTY;
      else
        st_q <= st_d;
    end

    // Bank next state from write and read events.
    always_comb begin
      st_d = st_q;
      unique case (st_q)
        EMPTY: begin
          if (wr_hit)
            st_d = wr_done ? FULL : FILLING;
        end
        FILLING: begin
          if (wr_hit && wr_done)
            st_d = FULL;
        end
        FULL: begin
          if (rd_hit)
            st_d = rd_done ? EMPTY : DRAINING;
        end
        DRAINING: begin
          if (rd_hit && rd_done)
            st_d = EMPTY;
        end
        default: st_d = EMPTY;
      endcase
    end
  end

  // Write pointer, column counter, tile size latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      c_q[0]  <= CW'(1);
      c_q[1]  <= CW'(1);
      r_q[0]  <= RW'(1);
      r_q[1]  <= RW'(1);
    end else if (wr_fire) begin
      if (wr_first) begin
        c_q[wr_bank] <= clamp_c(cfg_cols);
        r_q[wr_bank] <= clamp_r(cfg_rows);
      end
      if (wr_done) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + CIW'(1);
      end
    end
  end

  // Read pointer and row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (rd_fire) begin
      if (rd_done) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + RIW'(1);
      end
    end
  end

  // Column storage; each column holds a whole
  // input beat per bank, so a row read picks one
  // lane from every column.
  for (genvar c = 0; c < COL_DIM; c++) begin : gen_col
    logic [ROW_DIM-1:0][DATA_WIDTH-1:0] col_mem [2];
    logic                               lane_on;

    // Capture the beat into this column's bank slot.
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_cnt == CIW'(c)))
        col_mem[wr_bank] <= in_data;
    end

    assign lane_on = out_valid && (CW'(c) < rd_c);
    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] =
      lane_on ? col_mem[rd_bank][rd_cnt] : '0;
  end

endmodule

// File: tb/tb_transpose_pp.sv
// tb_transpose_pp: directed bench with row scoreboard
// for the ping-pong transposer.
module tb_transpose_pp;

  localparam int RD = 16;
  localparam int CD = 16;
  localparam int DW = 8;

  typedef struct {
    logic [CD*DW-1:0] d;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       cfg_cols;
  logic [4:0]       cfg_rows;
  logic             in_valid;
  logic             in_ready;
  logic [RD*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CD*DW-1:0] out_data;
  logic             out_last;
  logic             busy;

  exp_t       sb [$];
  logic [7:0] m [RD][CD];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         hs_cnt = 0;
  int         first_hs = 0;
  int         last_hs = 0;
  int         stalls = 0;
  logic [CD*DW-1:0] hold_d;
  logic             hold_l;
  logic             seen;

  transpose_pp #(
    .ROW_DIM(RD),
    .COL_DIM(CD),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_cols(cfg_cols),
    .cfg_rows(cfg_rows),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $error("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Output monitor: every row handshake is checked
  // against the oldest expected row.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (hs_cnt == 0)
        first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
      total++;
      assert (sb.size() != 0)
      else begin
        bad++;
        $error("FAIL extra_row got=%h exp=none",
               out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        assert (out_data === e.d && out_last === e.l)
        else begin
          bad++;
          $error("FAIL row got=%h/%b exp=%h/%b",
                 out_data, out_last, e.d, e.l);
        end
      end
    end
  end

  task automatic chk1(input string tag,
                      input logic got,
                      input logic exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chkv(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < RD; i++)
      for (int j = 0; j < CD; j++)
        m[i][j] = 8'($urandom);
  endtask

  task automatic push_exp(input int c, input int r);
    exp_t e;
    for (int j = 0; j < r; j++) begin
      e.d = '0;
      for (int k = 0; k < c; k++)
        e.d[k*DW +: DW] = m[j][k];
      e.l = (j == r - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_col(input int k);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < RD; i++)
      in_data[i*DW +: DW] = m[i][k];
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL in_timeout got=stalled exp=accept");
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int cc, input int rc,
                           input int ce, input int re,
                           input int cm);
    cfg_cols = 5'(cc);
    cfg_rows = 5'(rc);
    push_exp(ce, re);
    for (int k = 0; k < ce; k++) begin
      send_col(k);
      if (k == 0 && cm >= 0)
        cfg_cols = 5'(cm);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && sb.size() != 0; n++)
      @(posedge clk);
    @(posedge clk);
    #1;
    chkv("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cfg_cols  = 5'd4;
    cfg_rows  = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkv("rst_out_data", 128'(out_data), 128'(0));
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 pattern tile and first-row latency
    for (int r = 0; r < RD; r++)
      for (int k = 0; k < CD; k++)
        m[r][k] = 8'(4 * r + k);
    out_ready = 1'b1;
    cfg_cols = 5'd4;
    cfg_rows = 5'd4;
    push_exp(4, 4);
    for (int k = 0; k < 3; k++)
      send_col(k);
    chk1("lat_pre", out_valid, 1'b0);
    chk1("busy_partial", busy, 1'b1);
    send_col(3);
    chk1("lat_valid", out_valid, 1'b1);
    chkv("lat_row0", 128'(out_data), 128'h03020100);
    drain();
    chk1("idle_busy", busy, 1'b0);

    // three back-to-back 16x16 tiles
    stalls = 0;
    hs_cnt = 0;
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      send_tile(16, 16, 16, 16, -1);
    end
    drain();
    chkv("b2b_stalls", 128'(stalls), 128'(0));
    chkv("b2b_beats", 128'(hs_cnt), 128'(48));
    chkv("b2b_span", 128'(last_hs - first_hs),
         128'(47));

    // cfg change mid-tile is ignored
    fill_rand();
    send_tile(3, 2, 3, 2, 5);
    fill_rand();
    send_tile(5, 2, 5, 2, -1);
    drain();

    // both banks full with output stalled
    out_ready = 1'b0;
    fill_rand();
    send_tile(4, 4, 4, 4, -1);
    fill_rand();
    send_tile(4, 4, 4, 4, -1);
    chk1("full_in_ready", in_ready, 1'b0);
    chk1("full_busy", busy, 1'b1);
    chk1("full_valid", out_valid, 1'b1);
    hold_d = out_data;
    hold_l = out_last;
    repeat (3) @(posedge clk);
    #1;
    chkv("hold_data", 128'(out_data), 128'(hold_d));
    chk1("hold_last", out_last, hold_l);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      chk1("full_wait_ready", in_ready, 1'b0);
      if (out_last)
        seen = 1'b1;
    end
    chk1("full_last_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    chk1("ready_after_last", in_ready, 1'b1);
    drain();

    // reset mid-fill and mid-drain
    out_ready = 1'b0;
    fill_rand();
    send_tile(4, 4, 4, 4, -1);
    fill_rand();
    send_col(0);
    send_col(1);
    chk1("pre_rst_busy", busy, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_ready", in_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_last", out_last, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    fill_rand();
    send_tile(4, 4, 4, 4, -1);
    drain();

    // degenerate and clamped sizes
    fill_rand();
    send_tile(1, 1, 1, 1, -1);
    fill_rand();
    send_tile(0, 1, 1, 1, -1);
    fill_rand();
    send_tile(2, 0, 2, 1, -1);
    fill_rand();
    send_tile(31, 20, 16, 16, -1);
    drain();
    chk1("end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_pp.md
# transpose_pp

Ping-pong matrix transposer with ready/valid on both sides and a run-time tile size. It sits in the systolic intra-network between the operand/result buffers and the array. Each input beat carries one matrix column; each output beat emits one matrix row. Two storage banks let one tile fill while the previous tile drains, so back-to-back tiles stream without gaps.

## Interface
- ROW_DIM, 16, max matrix rows (elements per input beat, max output beats)
- COL_DIM, 16, max matrix columns (max input beats, elements per output beat)
- DATA_WIDTH, 8, element width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cfg_cols  in  $clog2(COL_DIM)+1  input beats per tile C; sampled on the first accepted beat of a tile
- cfg_rows  in  $clog2(ROW_DIM)+1  output beats per tile R; sampled with cfg_cols
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  ROW_DIM*DATA_WIDTH  column k: element r at [r*DATA_WIDTH +: DATA_WIDTH] = M[r][k]
- out_valid  out  1  output row valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- out_data  out  COL_DIM*DATA_WIDTH  row j: element c = M[j][c] for c<C, 0 for c>=C
- out_last  out  1  high with the final row (j=R-1) of a tile
- busy  out  1  any bank full, or current write tile partially filled

## Operation
- Storage: 2 banks × ROW_DIM×COL_DIM × DATA_WIDTH registers; per-bank latched C, R; bank_full[1:0]; wr_bank, rd_bank pointers; wr_cnt (column index), rd_cnt (row index).
- Config clamp on sampling: value 0 -> 1; value > DIM -> DIM.
- Write: in_ready = !bank_full[wr_bank]. On accept, column wr_cnt of wr_bank <= in_data; wr_cnt++. On accept with wr_cnt==C-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
- Read: out_valid = bank_full[rd_bank]. out_data = row rd_cnt of rd_bank, columns >= C masked to 0; out_data = 0 when out_valid=0. out_last = out_valid && rd_cnt==R-1.
- On out handshake: rd_cnt++; if out_last: bank_full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
- Input rows r >= R are stored but never emitted. Stale data in columns >= C is never visible due to masking.
- Per-bank state machine: EMPTY -> FILLING (first beat accepted) -> FULL (last beat accepted) -> DRAINING (first row consumed, R>1) -> EMPTY (last row consumed).
- Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle: both take effect. The same bank cannot do both, since fill requires !full and drain requires full.
- cfg_* changes mid-tile are ignored until the next tile's first beat.
- Reset (asynchronous assert, any time): bank_full=0, pointers=0, counters=0; partial and full tiles are discarded; storage contents need not be cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- All state is registered. in_ready, out_valid, out_data and out_last are combinational from registers only; no input-to-output combinational path.
- Latency: last column accepted at edge T -> out_valid=1 and row 0 presented in the cycle after T.
- Holding rule: while out_valid && !out_ready, out_data and out_last stay stable.
- Throughput: with both sides always ready and C==R, 1 beat/cycle each side, no bubbles between tiles. Otherwise the sustained tile rate is 1 per max(C,R) cycles.
- Both banks full -> in_ready=0 until the first drain completes; in_ready rises the cycle after that out_last handshake.

## Test plan
- 4×4 tile (C=R=4), in_data column k = {k+12,k+8,k+4,k} per element r=0..3, out_ready=1 -> rows j emit {4j+3,4j+2,4j+1,4j} in the low 4 lanes, remaining lanes 0; out_last on j=3; first out_valid 1 cycle after the 4th input accept.
- Three back-to-back 16×16 tiles with random data, both sides always ready -> 48 contiguous output beats, exact transpose of each tile, in_valid never stalled.
- C=3, R=2 with cfg changed to C=5 during beat 1 -> tile uses C=3: 2 output rows with lanes 3..15 = 0; the next tile uses the new cfg.
- out_ready=0 while sending 2 full tiles -> both banks full, in_ready=0, busy=1. Raise out_ready -> in_ready=1 the cycle after the first out_last handshake; out_data stable during the stall.
- Assert reset mid-tile (wr_cnt=2) and mid-drain -> next edge: out_valid=0, in_ready=1, busy=0. A following fresh tile transposes correctly.
- C=1, R=1, and cfg_cols=0 (clamped to 1) -> single accept fills the bank; one output beat with lane0=M[0][0], other lanes 0, out_last=1.
